// File: rtl/processor_defs.sv
// Shared processor definitions: end-of-program opcode and completion-monitor state encoding.
package processor_defs;

   localparam logic [7:0] ENDOP_OPCODE = 8'd28;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } mon_state_e;

endpackage

// File: rtl/endop_flag.sv
// Per-core sticky ENDOP detector; new_o pulses on the cycle the flag is about to set.
module endop_flag
   import processor_defs::*;
#(
   parameter int                   INS_WIDTH = 8,
   parameter logic [INS_WIDTH-1:0] ENDOP     = INS_WIDTH'(ENDOP_OPCODE)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic                 en_i,
   input  logic [INS_WIDTH-1:0] ins_i,
   output logic                 flag_o,
   output logic                 new_o
);

   logic flag_q;

   assign new_o  = en_i && (ins_i == ENDOP) && !flag_q;
   assign flag_o = flag_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_q <= 1'b0;
      end else if (clr_i) begin
         flag_q <= 1'b0;
      end else if (new_o) begin
         flag_q <= 1'b1;
      end
   end

endmodule

// File: rtl/core_endop_monitor.sv
// Multi-core completion detector: flags each core's ENDOP fetch, drains, then holds done until ack.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for start; results of the last run stay readable
// ST_RUN   | counting cycles, sampling instruction buses for ENDOP
// ST_DRAIN | all cores finished; down-counter runs out DRAIN_CYCLES
// ST_DONE  | results frozen, done held until ack
module core_endop_monitor
   import processor_defs::*;
#(
   parameter int                   NUM_CORES    = 4,
   parameter int                   INS_WIDTH    = 8,
   parameter logic [INS_WIDTH-1:0] ENDOP        = INS_WIDTH'(ENDOP_OPCODE),
   parameter int                   CNT_WIDTH    = 32,
   parameter int                   DRAIN_CYCLES = 5,
   localparam int                  LC_W         = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CORES*INS_WIDTH-1:0] ins,
   input  logic                           start,
   input  logic                           ack,
   output logic                           busy,
   output logic                           done,
   output logic [NUM_CORES-1:0]           core_done,
   output logic [LC_W-1:0]                last_core,
   output logic [CNT_WIDTH-1:0]           cycle_count
);

   localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

   mon_state_e           state_q;
   logic                 busy_q;
   logic                 done_q;
   logic [LC_W-1:0]      last_core_q;
   logic [LC_W-1:0]      last_core_d;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;
   logic [DW-1:0]        drain_q;
   logic [NUM_CORES-1:0] flag;
   logic [NUM_CORES-1:0] new_set;
   logic                 run_en;
   logic                 clr;

   assign run_en = (state_q == ST_RUN);
   assign clr    = (state_q == ST_IDLE) && start;

   for (genvar i = 0; i < NUM_CORES; i++) begin : g_flag
      endop_flag #(
         .INS_WIDTH (INS_WIDTH),
         .ENDOP     (ENDOP)
      ) u_flag (
         .clk    (clk),
         .rst    (rst),
         .clr_i  (clr),
         .en_i   (run_en),
         .ins_i  (ins[i*INS_WIDTH +: INS_WIDTH]),
         .flag_o (flag[i]),
         .new_o  (new_set[i])
      );
   end

   // Ascending scan so the highest newly-set index wins on simultaneous finishes.
   always_comb begin
      last_core_d = last_core_q;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (new_set[i]) last_core_d = LC_W'(i);
      end
   end

   assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         last_core_q <= '0;
         cnt_q       <= '0;
         drain_q     <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q     <= ST_RUN;
                  busy_q      <= 1'b1;
                  last_core_q <= '0;
                  cnt_q       <= '0;
               end
            end
            ST_RUN: begin
               cnt_q       <= cnt_d;
               last_core_q <= last_core_d;
               if (&flag) begin
                  state_q <= ST_DRAIN;
                  drain_q <= DRAIN_LOAD;
               end
            end
            ST_DRAIN: begin
               if (drain_q == '0) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= drain_q - DW'(1);
               end
            end
            ST_DONE: begin
               if (ack) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign core_done   = flag;
   assign last_core   = last_core_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_core_endop_monitor.sv
// Self-checking bench for core_endop_monitor: scoreboard of expected run results popped when done rises.
module tb_core_endop_monitor;

   localparam int DRAIN = 5;

   typedef struct {
      int         edge_n;
      int         cnt;
      int         lc;
      logic [3:0] cd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ins = '0;
   logic        start = 1'b0;
   logic        ack = 1'b0;
   logic        busy, done;
   logic [3:0]  core_done;
   logic [1:0]  last_core;
   logic [31:0] cycle_count;

   logic        rst2 = 1'b1;
   logic [31:0] ins2 = '0;
   logic        start2 = 1'b0;
   logic        ack2 = 1'b0;
   logic        busy2, done2;
   logic [3:0]  core_done2;
   logic [1:0]  last_core2;
   logic [3:0]  cycle_count2;

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   core_endop_monitor dut (
      .clk(clk), .rst(rst), .ins(ins), .start(start), .ack(ack),
      .busy(busy), .done(done), .core_done(core_done),
      .last_core(last_core), .cycle_count(cycle_count)
   );

   core_endop_monitor #(.CNT_WIDTH(4)) dut_sat (
      .clk(clk), .rst(rst2), .ins(ins2), .start(start2), .ack(ack2),
      .busy(busy2), .done(done2), .core_done(core_done2),
      .last_core(last_core2), .cycle_count(cycle_count2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_cd"},   64'(core_done), 64'(0));
      chk({tag, "_lc"},   64'(last_core), 64'(0));
      chk({tag, "_cnt"},  64'(cycle_count), 64'(0));
   endtask

   // Runs one complete run with per-core ENDOP edges f0..f3 (relative to the start edge E0).
   task automatic run_case(input int f0, input int f1, input int f2, input int f3);
      int         fin[4];
      int         last;
      int         lc;
      bit         seen;
      exp_t       e;
      exp_t       got;
      logic [3:0] m;
      fin = '{f0, f1, f2, f3};
      last = 0;
      for (int i = 0; i < 4; i++) if (fin[i] > last) last = fin[i];
      lc = 0;
      for (int i = 0; i < 4; i++) if (fin[i] == last) lc = i;
      e.edge_n = last + 1 + DRAIN;
      e.cnt    = last + 1;
      e.lc     = lc;
      e.cd     = 4'hF;
      sb.push_back(e);

      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_busy", 64'(busy), 64'(1));
      chk("start_cnt",  64'(cycle_count), 64'(0));
      chk("start_cd",   64'(core_done), 64'(0));

      seen = 1'b0;
      for (int k = 1; k <= 60 && !seen; k++) begin
         for (int i = 0; i < 4; i++)
            ins[i*8 +: 8] = (k == fin[i]) ? 8'd28 : 8'($urandom_range(0, 27));
         step();
         m = '0;
         for (int i = 0; i < 4; i++) if (fin[i] <= k) m[i] = 1'b1;
         chk("core_done", 64'(core_done), 64'(m));
         chk("cnt_run", 64'(cycle_count), 64'((k <= last + 1) ? k : last + 1));
         if (k == last + 1) chk("drain_busy", 64'(busy), 64'(1));
         if (done) begin
            seen = 1'b1;
            got = sb.pop_front();
            chk("done_edge", 64'(k), 64'(got.edge_n));
            chk("done_cnt",  64'(cycle_count), 64'(got.cnt));
            chk("done_lc",   64'(last_core), 64'(got.lc));
            chk("done_cd",   64'(core_done), 64'(got.cd));
            chk("done_busy", 64'(busy), 64'(0));
         end
      end
      if (!seen) chk("done_timeout", 64'(0), 64'(1));
      ins = '0;
   endtask

   initial begin
      #12;
      chk_zero("reset");
      rst  = 1'b0;
      rst2 = 1'b0;
      step();
      chk_zero("idle");

      // Saturation with a 4-bit counter and no ENDOP.
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         chk("sat_cnt",  64'(cycle_count2), 64'((k < 15) ? k : 15));
         chk("sat_busy", 64'(busy2), 64'(1));
      end
      rst2 = 1'b1;

      // Pre-start ENDOP on core 2 plus stray start/ack in RUN.
      ins[16 +: 8] = 8'd28;
      step();
      step();
      chk("pre_cd", 64'(core_done), 64'(0));
      start = 1'b1;
      step();
      start = 1'b0;
      ins = '0;
      ins[0 +: 8]  = 8'd28;
      ins[8 +: 8]  = 8'd28;
      ins[24 +: 8] = 8'd28;
      for (int k = 1; k <= 12; k++) begin
         start = (k == 4);
         ack   = (k == 6);
         step();
         chk("stray_cd",   64'(core_done), 64'(4'b1011));
         chk("stray_busy", 64'(busy), 64'(1));
         chk("stray_done", 64'(done), 64'(0));
         chk("stray_cnt",  64'(cycle_count), 64'(k));
      end
      start = 1'b0;
      ack   = 1'b0;
      ins   = '0;
      rst = 1'b1;
      #1;
      chk_zero("abort3");
      rst = 1'b0;
      step();

      // Simultaneous finish at E4, then start+ack together in DONE.
      run_case(4, 4, 4, 4);
      start = 1'b1;
      ack   = 1'b1;
      step();
      start = 1'b0;
      ack   = 1'b0;
      chk("hs_done", 64'(done), 64'(0));
      chk("hs_busy", 64'(busy), 64'(0));
      chk("hs_cnt",  64'(cycle_count), 64'(5));
      chk("hs_lc",   64'(last_core), 64'(3));
      for (int k = 0; k < 3; k++) step();
      chk("hs_idle_busy", 64'(busy), 64'(0));
      chk("hs_idle_cnt",  64'(cycle_count), 64'(5));

      // Staggered finish; the fresh start clears the held results.
      run_case(3, 5, 7, 10);
      for (int k = 0; k < 3; k++) step();
      chk("hold_done", 64'(done), 64'(1));
      chk("hold_cnt",  64'(cycle_count), 64'(11));
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("ack_done", 64'(done), 64'(0));

      // Reset mid-run with cores 0 and 1 flagged.
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         ins = '0;
         if (k == 2) ins[0 +: 8] = 8'd28;
         if (k == 3) ins[8 +: 8] = 8'd28;
         step();
      end
      ins = '0;
      chk("pre_rst_cd", 64'(core_done), 64'(4'b0011));
      #2;
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      #3;
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("post_rst_busy", 64'(busy), 64'(0));
         chk("post_rst_done", 64'(done), 64'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
